tawas_au_mc: RTL and testbench

//  Parametrised, multi-cycle successor of the Tawas arithmetic unit. Reads operands from the flat

---
 rtl/tawas_au_mc_if.sv | 33 +++
 rtl/tawas_au_mc.sv | 199 +++++++++++++++++++
 tb/tb_tawas_au_mc.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tawas_au_mc_if.sv
// tawas_au_mc_if: register-file read bus, issue handshake and writeback port of the Tawas AU.
// master = the issuing pipeline side, slave = the arithmetic unit.
interface tawas_au_mc_if #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 8
);
    localparam int REG_W = $clog2(REG_CNT);
    localparam int OP_W  = 4 + 3 * REG_W;

    logic [REG_CNT*DATA_W-1:0] regdata;
    logic                      rf_imm_en;
    logic [REG_W-1:0]          rf_imm_reg;
    logic [DATA_W-1:0]         rf_imm;
    logic                      au_op_en;
    logic [OP_W-1:0]           au_op;
    logic                      au_busy;
    logic                      au_err;
    logic                      wb_au_en;
    logic [REG_W-1:0]          wb_au_reg;
    logic [DATA_W-1:0]         wb_au_data;
    logic                      wb_au_flags_en;
    logic [7:0]                wb_au_flags;

    modport master (
        output regdata, rf_imm_en, rf_imm_reg, rf_imm, au_op_en, au_op,
        input  au_busy, au_err, wb_au_en, wb_au_reg, wb_au_data, wb_au_flags_en, wb_au_flags
    );

    modport slave (
        input  regdata, rf_imm_en, rf_imm_reg, rf_imm, au_op_en, au_op,
        output au_busy, au_err, wb_au_en, wb_au_reg, wb_au_data, wb_au_flags_en, wb_au_flags
    );
endinterface

// File: rtl/tawas_au_mc.sv
// tawas_au_mc: Tawas arithmetic unit, single-cycle ALU ops plus registered writeback.
// Define TAWAS_AU_MULDIV_EN to build the iterative multiply/divide engine (funcs 9-12).
module tawas_au_mc #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 8
) (
    input logic          clk,
    input logic          rst,
    tawas_au_mc_if.slave au
);
    localparam int REG_W = $clog2(REG_CNT);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int MSB   = DATA_W - 1;

    typedef enum logic [3:0] {
        F_ADD   = 4'd0,
        F_SUB   = 4'd1,
        F_AND   = 4'd2,
        F_OR    = 4'd3,
        F_XOR   = 4'd4,
        F_SHL   = 4'd5,
        F_SHR   = 4'd6,
        F_ASR   = 4'd7,
        F_CMP   = 4'd8,
        F_MULLO = 4'd9,
        F_MULHU = 4'd10,
        F_DIVU  = 4'd11,
        F_REMU  = 4'd12
    } func_e;

    function automatic logic [7:0] pack_flags(input logic v, input logic c,
                                              input logic [DATA_W-1:0] r);
        return {4'b0, v, c, r[MSB], (r == '0)};
    endfunction

    func_e             func;
    logic [REG_W-1:0]  rd, ra, rb;
    logic [DATA_W-1:0] opa, opb;
    logic [SH_W-1:0]   sh_amt;
    logic              is_single, is_iter, busy;

    assign func   = func_e'(au.au_op[3:0]);
    assign rd     = au.au_op[4 +: REG_W];
    assign ra     = au.au_op[4 + REG_W +: REG_W];
    assign rb     = au.au_op[4 + 2*REG_W +: REG_W];
    // Immediate override is applied per operand, so ra == rb == rf_imm_reg replaces both.
    assign opa    = (au.rf_imm_en && au.rf_imm_reg == ra) ? au.rf_imm : au.regdata[ra*DATA_W +: DATA_W];
    assign opb    = (au.rf_imm_en && au.rf_imm_reg == rb) ? au.rf_imm : au.regdata[rb*DATA_W +: DATA_W];
    assign sh_amt = opb[SH_W-1:0];

    assign is_single = (au.au_op[3:0] <= 4'd8);
    assign au.au_busy = busy;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c, alu_v;
    logic [DATA_W:0]   sum, shl_w, shr_w;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        sum     = '0;
        shl_w   = '0;
        shr_w   = '0;
        case (func)
            F_ADD: begin
                sum     = {1'b0, opa} + {1'b0, opb};
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (opa[MSB] == opb[MSB]) && (alu_res[MSB] != opa[MSB]);
            end
            F_SUB, F_CMP: begin
                // Two's-complement subtract: carry-out of A + ~B + 1 is the no-borrow flag.
                sum     = {1'b0, opa} + {1'b0, ~opb} + (DATA_W+1)'(1);
                alu_res = sum[MSB:0];
                alu_c   = sum[DATA_W];
                alu_v   = (opa[MSB] != opb[MSB]) && (alu_res[MSB] != opa[MSB]);
            end
            F_AND: alu_res = opa & opb;
            F_OR:  alu_res = opa | opb;
            F_XOR: alu_res = opa ^ opb;
            F_SHL: begin
                shl_w   = {1'b0, opa} << sh_amt;
                alu_res = shl_w[MSB:0];
                alu_c   = shl_w[DATA_W];
            end
            F_SHR: begin
                shr_w   = {opa, 1'b0} >> sh_amt;
                alu_res = shr_w[DATA_W:1];
                alu_c   = shr_w[0];
            end
            F_ASR: alu_res = $signed(opa) >>> sh_amt;
            default: ;
        endcase
    end

`ifdef TAWAS_AU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e            state;
    logic [SH_W-1:0]   cnt;
    logic [DATA_W-1:0] hi, lo, mb, hi_nxt, lo_nxt, it_res, div_diff;
    logic [DATA_W:0]   mul_sum, div_sh;
    func_e             it_func;
    logic [REG_W-1:0]  it_rd;
    logic              div_zero, is_div, div_ge, start;

    assign is_iter = (au.au_op[3:0] >= 4'd9) && (au.au_op[3:0] <= 4'd12);
    assign busy    = (state != S_IDLE);
    assign start   = au.au_op_en && !busy && is_iter;

    // One step per RUN cycle: {hi,lo} is the shift-add product or the remainder/quotient pair.
    always_comb begin
        is_div   = (it_func == F_DIVU) || (it_func == F_REMU);
        mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, mb} : '0);
        div_sh   = {hi, lo[MSB]};
        div_ge   = (div_sh >= {1'b0, mb});
        div_diff = div_sh[MSB:0] - mb;
        if (is_div) begin
            hi_nxt = div_ge ? div_diff : div_sh[MSB:0];
            lo_nxt = {lo[MSB-1:0], div_ge};
        end else begin
            {hi_nxt, lo_nxt} = {mul_sum, lo[MSB:1]};
        end
        it_res = (it_func == F_MULHU || it_func == F_REMU) ? hi_nxt : lo_nxt;
    end
`else
    assign is_iter = 1'b0;
    assign busy    = 1'b0;
`endif

    // NOTE: state and registered outputs use non-blocking assignments only, so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            au.au_err         <= 1'b0;
            au.wb_au_en       <= 1'b0;
            au.wb_au_reg      <= '0;
            au.wb_au_data     <= '0;
            au.wb_au_flags_en <= 1'b0;
            au.wb_au_flags    <= '0;
`ifdef TAWAS_AU_MULDIV_EN
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            mb       <= '0;
            it_func  <= F_MULLO;
            it_rd    <= '0;
            div_zero <= 1'b0;
`endif
        end else begin
            au.au_err         <= 1'b0;
            au.wb_au_en       <= 1'b0;
            au.wb_au_flags_en <= 1'b0;
            if (au.au_op_en) begin
                if (busy || !(is_single || is_iter)) begin
                    au.au_err <= 1'b1;
                end else if (is_single) begin
                    au.wb_au_en       <= (func != F_CMP);
                    au.wb_au_flags_en <= 1'b1;
                    au.wb_au_reg      <= rd;
                    au.wb_au_data     <= alu_res;
                    au.wb_au_flags    <= pack_flags(alu_v, alu_c, alu_res);
                end
            end
`ifdef TAWAS_AU_MULDIV_EN
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_RUN;
                        cnt      <= '0;
                        hi       <= '0;
                        lo       <= opa;
                        mb       <= opb;
                        it_func  <= func;
                        it_rd    <= rd;
                        div_zero <= (opb == '0);
                    end
                end
                S_RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == SH_W'(DATA_W - 1)) begin
                        state             <= S_DONE;
                        au.wb_au_en       <= 1'b1;
                        au.wb_au_flags_en <= 1'b1;
                        au.wb_au_reg      <= it_rd;
                        au.wb_au_data     <= it_res;
                        au.wb_au_flags    <= pack_flags(is_div && div_zero, 1'b0, it_res);
                    end
                end
                default: state <= S_IDLE;
            endcase
`endif
        end
    end
endmodule

// File: tb/tb_tawas_au_mc.sv
// tb_tawas_au_mc: table-driven and randomized check of tawas_au_mc against a plain-arithmetic model.
// Iterative-op expectations follow whether TAWAS_AU_MULDIV_EN is defined for the build.
module tb_tawas_au_mc;
    localparam int DATA_W  = 32;
    localparam int REG_CNT = 8;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [31:0] regs [REG_CNT];

    tawas_au_mc_if #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) bus ();

    tawas_au_mc #(.DATA_W(DATA_W), .REG_CNT(REG_CNT)) dut (
        .clk(clk),
        .rst(rst),
        .au (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic        en;
        logic        fen;
        logic        err;
        logic [31:0] data;
        logic [7:0]  flags;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_regs();
        for (int i = 0; i < REG_CNT; i++) bus.regdata[i*32 +: 32] = regs[i];
    endtask

    function automatic logic [12:0] mk_op(input logic [3:0] f, input logic [2:0] rd,
                                          input logic [2:0] ra, input logic [2:0] rb);
        return {rb, ra, rd, f};
    endfunction

    // Reference model straight from the arithmetic definitions of each function.
    function automatic void model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] res, output logic [7:0] fl,
                                  output logic en, output logic fen, output logic err, output logic it);
        longint sa, sb, sr;
        logic [63:0] w;
        int amt;
        logic c, v;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        amt = int'(b[4:0]);
        res = '0; c = 1'b0; v = 1'b0; en = 1'b1; fen = 1'b1; err = 1'b0; it = 1'b0;
        case (f)
            4'd0: begin
                w = {32'd0, a} + {32'd0, b}; res = w[31:0]; c = w[32];
                sr = sa + sb; v = (sr != longint'($signed(res)));
            end
            4'd1, 4'd8: begin
                res = a - b; c = (a >= b);
                sr = sa - sb; v = (sr != longint'($signed(res)));
                if (f == 4'd8) en = 1'b0;
            end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: begin res = a << amt; c = (amt != 0) ? a[32-amt] : 1'b0; end
            4'd6: begin res = a >> amt; c = (amt != 0) ? a[amt-1] : 1'b0; end
            4'd7: res = $unsigned($signed(a) >>> amt);
`ifdef TAWAS_AU_MULDIV_EN
            4'd9, 4'd10: begin
                w = {32'd0, a} * {32'd0, b}; res = (f == 4'd9) ? w[31:0] : w[63:32]; it = 1'b1;
            end
            4'd11: begin res = (b == 0) ? 32'hFFFF_FFFF : a / b; v = (b == 0); it = 1'b1; end
            4'd12: begin res = (b == 0) ? a : a % b; v = (b == 0); it = 1'b1; end
`endif
            default: begin en = 1'b0; fen = 1'b0; err = 1'b1; end
        endcase
        fl = {4'b0, v, c, res[31], (res == 32'd0)};
    endfunction

    task automatic check_wb(input string name, input logic en, input logic fen, input logic err,
                            input logic [31:0] data, input logic [7:0] fl, input logic [2:0] rd);
        check({name, ".ctl"}, {61'd0, bus.wb_au_en, bus.wb_au_flags_en, bus.au_err}, {61'd0, en, fen, err});
        if (en) begin
            check({name, ".data"}, {32'd0, bus.wb_au_data}, {32'd0, data});
            check({name, ".reg"}, {61'd0, bus.wb_au_reg}, {61'd0, rd});
        end
        if (fen) check({name, ".flags"}, {56'd0, bus.wb_au_flags}, {56'd0, fl});
    endtask

`ifdef TAWAS_AU_MULDIV_EN
    // Issue an iterative op from r1/r2; optionally poke a refused ADD at sample index inject.
    task automatic run_iter(input string name, input logic [3:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [2:0] rd, input int inject);
        logic [31:0] er, got_data;
        logic [7:0]  ef, got_fl;
        logic        een, efen, eerr, eit, got_fen;
        logic [2:0]  got_rd;
        int          busy_n, wb_at;
        model(f, a, b, er, ef, een, efen, eerr, eit);
        regs[1] = a; regs[2] = b; apply_regs();
        bus.rf_imm_en = 1'b0;
        bus.au_op     = mk_op(f, rd, 3'd1, 3'd2);
        bus.au_op_en  = 1'b1;
        tick();
        bus.au_op_en = 1'b0;
        busy_n = 0; wb_at = -1; got_data = '0; got_fl = '0; got_fen = 1'b0; got_rd = '0;
        for (int i = 0; i < 3 * DATA_W; i++) begin
            if (inject >= 0 && i == inject + 1)
                check({name, ".refuse"}, {62'd0, bus.au_err, bus.wb_au_en}, {62'd0, 2'b10});
            if (!bus.au_busy) break;
            busy_n++;
            if (bus.wb_au_en) begin
                wb_at = i; got_data = bus.wb_au_data; got_fl = bus.wb_au_flags;
                got_fen = bus.wb_au_flags_en; got_rd = bus.wb_au_reg;
            end
            if (i == 1) begin
                regs[1] = ~a; regs[2] = a ^ b; apply_regs();
                bus.rf_imm_en = 1'b1; bus.rf_imm_reg = 3'd2; bus.rf_imm = 32'h1234_5678;
            end
            if (i == inject) begin
                bus.au_op    = mk_op(4'd0, 3'd6, 3'd1, 3'd2);
                bus.au_op_en = 1'b1;
            end else begin
                bus.au_op_en = 1'b0;
            end
            tick();
        end
        bus.au_op_en  = 1'b0;
        bus.rf_imm_en = 1'b0;
        check({name, ".busy_cycles"}, 64'(busy_n), 64'(DATA_W + 1));
        check({name, ".wb_cycle"}, 64'(wb_at), 64'(DATA_W));
        check({name, ".data"}, {32'd0, got_data}, {32'd0, er});
        check({name, ".flags"}, {55'd0, got_fen, got_fl}, {55'd0, 1'b1, ef});
        check({name, ".reg"}, {61'd0, got_rd}, {61'd0, rd});
    endtask
`endif

    vec_t vecs [$];

    initial begin
        logic [31:0] er, a, b;
        logic [7:0]  ef;
        logic        een, efen, eerr, eit;
        logic [3:0]  f;
        logic [2:0]  ra, rb, rd;
        int          wb_seen;

        vecs.push_back('{4'd0,  32'hFFFF_FFFF, 32'h1,         1, 1, 0, 32'h0,         8'h05});
        vecs.push_back('{4'd0,  32'h7FFF_FFFF, 32'h1,         1, 1, 0, 32'h8000_0000, 8'h0A});
        vecs.push_back('{4'd1,  32'h8000_0000, 32'h1,         1, 1, 0, 32'h7FFF_FFFF, 8'h0C});
        vecs.push_back('{4'd1,  32'h1,         32'h2,         1, 1, 0, 32'hFFFF_FFFF, 8'h02});
        vecs.push_back('{4'd8,  32'h8000_0000, 32'h1,         0, 1, 0, 32'h0,         8'h0C});
        vecs.push_back('{4'd8,  32'h5,         32'h5,         0, 1, 0, 32'h0,         8'h05});
        vecs.push_back('{4'd2,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 1, 1, 0, 32'h00F0_00F0, 8'h00});
        vecs.push_back('{4'd3,  32'h8000_0000, 32'h1,         1, 1, 0, 32'h8000_0001, 8'h02});
        vecs.push_back('{4'd4,  32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 1, 0, 32'h0,         8'h01});
        vecs.push_back('{4'd5,  32'h8000_0001, 32'h1,         1, 1, 0, 32'h2,         8'h04});
        vecs.push_back('{4'd5,  32'h8000_0000, 32'h0,         1, 1, 0, 32'h8000_0000, 8'h02});
        vecs.push_back('{4'd5,  32'h3,         32'd31,        1, 1, 0, 32'h8000_0000, 8'h06});
        vecs.push_back('{4'd6,  32'h3,         32'h1,         1, 1, 0, 32'h1,         8'h04});
        vecs.push_back('{4'd6,  32'h2,         32'h21,        1, 1, 0, 32'h1,         8'h00});
        vecs.push_back('{4'd7,  32'h8000_0000, 32'h24,        1, 1, 0, 32'hF800_0000, 8'h02});
        vecs.push_back('{4'd13, 32'h1,         32'h1,         0, 0, 1, 32'h0,         8'h00});
        vecs.push_back('{4'd15, 32'h1,         32'h1,         0, 0, 1, 32'h0,         8'h00});
`ifndef TAWAS_AU_MULDIV_EN
        vecs.push_back('{4'd9,  32'h3,         32'h5,         0, 0, 1, 32'h0,         8'h00});
        vecs.push_back('{4'd11, 32'h7,         32'h0,         0, 0, 1, 32'h0,         8'h00});
`endif

        rst = 1'b1;
        bus.regdata = '0; bus.rf_imm_en = 1'b0; bus.rf_imm_reg = '0; bus.rf_imm = '0;
        bus.au_op_en = 1'b0; bus.au_op = '0;
        for (int i = 0; i < REG_CNT; i++) regs[i] = 32'h1111_1111 * i;
        apply_regs();
        tick(); tick();
        check("reset.outputs",
              {bus.au_busy, bus.au_err, bus.wb_au_en, bus.wb_au_flags_en, bus.wb_au_reg, bus.wb_au_data, bus.wb_au_flags},
              '0);
        rst = 1'b0;
        tick();

        // Directed table, issued back to back.
        foreach (vecs[k]) begin
            regs[1] = vecs[k].a; regs[2] = vecs[k].b; apply_regs();
            bus.au_op    = mk_op(vecs[k].f, 3'd3, 3'd1, 3'd2);
            bus.au_op_en = 1'b1;
            tick();
            check_wb($sformatf("vec%0d", k), vecs[k].en, vecs[k].fen, vecs[k].err,
                     vecs[k].data, vecs[k].flags, 3'd3);
            check($sformatf("vec%0d.busy", k), {63'd0, bus.au_busy}, 64'd0);
        end
        bus.au_op_en = 1'b0;
        tick();
        check("idle.no_wb", {62'd0, bus.wb_au_en, bus.au_err}, 64'd0);

        // Immediate override on both operands, then on ra only.
        regs[2] = 32'h1234_5678; regs[1] = 32'h100; apply_regs();
        bus.rf_imm_en = 1'b1; bus.rf_imm_reg = 3'd2; bus.rf_imm = 32'h10;
        bus.au_op = mk_op(4'd0, 3'd5, 3'd2, 3'd2); bus.au_op_en = 1'b1;
        tick();
        check_wb("imm.both", 1'b1, 1'b1, 1'b0, 32'h20, 8'h00, 3'd5);
        bus.rf_imm_reg = 3'd1;
        bus.au_op = mk_op(4'd1, 3'd5, 3'd1, 3'd2);
        tick();
        check_wb("imm.ra", 1'b1, 1'b1, 1'b0, 32'h10 - 32'h1234_5678, 8'h02, 3'd5);
        bus.rf_imm_en = 1'b0; bus.au_op_en = 1'b0;

`ifdef TAWAS_AU_MULDIV_EN
        run_iter("mulhu", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd7, 5);
        regs[1] = 32'd40; regs[2] = 32'd2; apply_regs();
        bus.au_op = mk_op(4'd0, 3'd4, 3'd1, 3'd2); bus.au_op_en = 1'b1;
        tick();
        bus.au_op_en = 1'b0;
        check_wb("after_done.accept", 1'b1, 1'b1, 1'b0, 32'd42, 8'h00, 3'd4);
        run_iter("divu0", 4'd11, 32'd7, 32'd0, 3'd2, DATA_W);
        run_iter("remu0", 4'd12, 32'd7, 32'd0, 3'd1, -1);
        run_iter("mullo", 4'd9, 32'h0001_0003, 32'h0002_0005, 3'd0, -1);
        run_iter("divu", 4'd11, 32'd1000, 32'd7, 3'd3, -1);

        // Reset while the engine is running drops the op.
        regs[1] = 32'd99; regs[2] = 32'd3; apply_regs();
        bus.au_op = mk_op(4'd11, 3'd6, 3'd1, 3'd2); bus.au_op_en = 1'b1;
        tick();
        bus.au_op_en = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("rst_in_run.busy_before", {63'd0, bus.au_busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_in_run.busy_after", {62'd0, bus.au_busy, bus.wb_au_en}, 64'd0);
        wb_seen = 0;
        for (int i = 0; i < DATA_W + 8; i++) begin
            tick();
            if (bus.wb_au_en || bus.au_busy) wb_seen++;
        end
        check("rst_in_run.no_wb", 64'(wb_seen), 64'd0);
`else
        regs[1] = 32'd3; regs[2] = 32'd5; apply_regs();
        bus.au_op = mk_op(4'd9, 3'd3, 3'd1, 3'd2); bus.au_op_en = 1'b1;
        tick();
        bus.au_op_en = 1'b0;
        check("nomd.mullo", {61'd0, bus.au_err, bus.wb_au_en, bus.au_busy}, {61'd0, 3'b100});
        wb_seen = 0;
        for (int i = 0; i < DATA_W + 4; i++) begin
            tick();
            if (bus.wb_au_en || bus.au_busy || bus.au_err) wb_seen++;
        end
        check("nomd.quiet", 64'(wb_seen), 64'd0);
`endif

        // Randomized ops against the model.
        for (int n = 0; n < 160; n++) begin
            for (int i = 0; i < REG_CNT; i++) regs[i] = $urandom();
            if ($urandom_range(0, 3) == 0) regs[$urandom_range(0, 7)] = regs[$urandom_range(0, 7)];
            apply_regs();
            f  = 4'($urandom_range(0, 15));
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            bus.rf_imm_en  = 1'($urandom_range(0, 1));
            bus.rf_imm_reg = 3'($urandom_range(0, 7));
            bus.rf_imm     = $urandom();
            a = (bus.rf_imm_en && bus.rf_imm_reg == ra) ? bus.rf_imm : regs[ra];
            b = (bus.rf_imm_en && bus.rf_imm_reg == rb) ? bus.rf_imm : regs[rb];
            model(f, a, b, er, ef, een, efen, eerr, eit);
`ifdef TAWAS_AU_MULDIV_EN
            if (eit) begin
                run_iter($sformatf("rnd%0d", n), f, a, b, rd, -1);
                continue;
            end
`endif
            bus.au_op    = mk_op(f, rd, ra, rb);
            bus.au_op_en = 1'b1;
            tick();
            check_wb($sformatf("rnd%0d_f%0d", n, f), een, efen, eerr, er, ef, rd);
        end
        bus.au_op_en  = 1'b0;
        bus.rf_imm_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
